// File: rtl/acc_multi.sv
// Multi-channel saturating hit-count accumulator: popcount stage, then per-channel commit.
// A last beat closes its channel's round and hands the count out through a valid/ready port.
module acc_multi #(
  parameter int unsigned LANES  = 4,
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             acc_en_i,
  output logic             in_ready_o,
  input  logic [CH_W-1:0]  ch_sel_i,
  input  logic [LANES-1:0] hit_i,
  input  logic             last_i,
  input  logic             acc_clear_i,
  output logic             cand_valid_o,
  input  logic             cand_ready_i,
  output logic [CH_W-1:0]  cand_ch_o,
  output logic [CNT_W-1:0] cand_o,
  output logic             cand_sat_o
);

  localparam int unsigned PopW = $clog2(LANES + 1);
  localparam int unsigned SumW = CNT_W + 1;
  localparam logic [CH_W:0] NumChL = (CH_W + 1)'(NUM_CH);

  logic [PopW-1:0]  pop;
  logic             ch_ok;
  logic             stall;
  logic             commit;
  logic [SumW-1:0]  sum;
  logic             ovf;
  logic [CNT_W-1:0] res;

  logic             s1_valid_q, s1_valid_d;
  logic [PopW-1:0]  s1_cnt_q, s1_cnt_d;
  logic [CH_W-1:0]  s1_ch_q, s1_ch_d;
  logic             s1_last_q, s1_last_d;

  logic [CNT_W-1:0] acc_q [NUM_CH];
  logic [CNT_W-1:0] acc_d [NUM_CH];
  logic [NUM_CH-1:0] sat_q, sat_d;

  logic             cand_valid_q, cand_valid_d;
  logic [CH_W-1:0]  cand_ch_q, cand_ch_d;
  logic [CNT_W-1:0] cand_q, cand_d;
  logic             cand_sat_q, cand_sat_d;

  always_comb begin
    pop = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      pop = pop + PopW'(hit_i[i]);
    end
  end

  assign ch_ok = ({1'b0, ch_sel_i} < NumChL);
  // Only a last beat can be blocked, and only by an unconsumed result.
  assign stall      = s1_valid_q & s1_last_q & cand_valid_q & ~cand_ready_i;
  assign in_ready_o = ~stall;
  assign commit     = s1_valid_q & ~stall & ~acc_clear_i;

  assign sum = SumW'(acc_q[s1_ch_q]) + SumW'(s1_cnt_q);
  assign ovf = sum[CNT_W];
  assign res = ovf ? {CNT_W{1'b1}} : sum[CNT_W-1:0];

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_cnt_d   = s1_cnt_q;
    s1_ch_d    = s1_ch_q;
    s1_last_d  = s1_last_q;
    if (acc_clear_i) begin
      s1_valid_d = 1'b0;
    end else if (!stall) begin
      s1_valid_d = acc_en_i & ch_ok;
      s1_cnt_d   = pop;
      s1_ch_d    = ch_sel_i;
      s1_last_d  = last_i;
    end
  end

  always_comb begin
    acc_d = acc_q;
    sat_d = sat_q;
    if (acc_clear_i) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        acc_d[i] = '0;
      end
      sat_d = '0;
    end else if (commit) begin
      if (s1_last_q) begin
        acc_d[s1_ch_q] = '0;
        sat_d[s1_ch_q] = 1'b0;
      end else begin
        acc_d[s1_ch_q] = res;
        sat_d[s1_ch_q] = sat_q[s1_ch_q] | ovf;
      end
    end
  end

  // Result register is independent of clear; a new last reload wins over a transfer.
  always_comb begin
    cand_valid_d = cand_valid_q;
    cand_ch_d    = cand_ch_q;
    cand_d       = cand_q;
    cand_sat_d   = cand_sat_q;
    if (cand_valid_q && cand_ready_i) begin
      cand_valid_d = 1'b0;
    end
    if (commit && s1_last_q) begin
      cand_valid_d = 1'b1;
      cand_ch_d    = s1_ch_q;
      cand_d       = res;
      cand_sat_d   = sat_q[s1_ch_q] | ovf;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid_q   <= 1'b0;
      s1_cnt_q     <= '0;
      s1_ch_q      <= '0;
      s1_last_q    <= 1'b0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        acc_q[i] <= '0;
      end
      sat_q        <= '0;
      cand_valid_q <= 1'b0;
      cand_ch_q    <= '0;
      cand_q       <= '0;
      cand_sat_q   <= 1'b0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_cnt_q     <= s1_cnt_d;
      s1_ch_q      <= s1_ch_d;
      s1_last_q    <= s1_last_d;
      acc_q        <= acc_d;
      sat_q        <= sat_d;
      cand_valid_q <= cand_valid_d;
      cand_ch_q    <= cand_ch_d;
      cand_q       <= cand_d;
      cand_sat_q   <= cand_sat_d;
    end
  end

  assign cand_valid_o = cand_valid_q;
  assign cand_ch_o    = cand_ch_q;
  assign cand_o       = cand_q;
  assign cand_sat_o   = cand_sat_q;

endmodule
